// File: rtl/multiplicador_seq_if.sv
// Operand/result bundle for the sequential multiplier (init/done handshake).
interface multiplicador_seq_if #(
  parameter int unsigned WIDTH = 3
);
  logic               init;
  logic [WIDTH-1:0]   portA;
  logic [WIDTH-1:0]   portB;
  logic [2*WIDTH-1:0] P;
  logic               done;

  // Controller side: issues operands and start, observes result.
  modport master (output init, portA, portB, input P, done);
  // Multiplier side.
  modport slave  (input init, portA, portB, output P, done);
endinterface

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier, P = portA * portB over 2*WIDTH+popcount(B) clocks.
// Optional MULT_SIGNED_EN: two's complement operands, multiplied as magnitudes with the
// sign reapplied when the result is committed to P.
module multiplicador_seq #(
  parameter int unsigned WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  multiplicador_seq_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {START, CHECK, ADD, SHIFT, END} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   pp_q;
  logic [CW-1:0]   ct_q;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [PW-1:0]    result_c;

`ifdef MULT_SIGNED_EN
  logic sign_q;

  // Magnitudes of the operands; the most-negative value maps to 2^(WIDTH-1).
  assign mag_a_c  = bus.portA[WIDTH-1] ? -bus.portA : bus.portA;
  assign mag_b_c  = bus.portB[WIDTH-1] ? -bus.portB : bus.portB;
  assign result_c = sign_q ? -pp_q : pp_q;

  // Product sign captured at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
    end else if (state == START && bus.init) begin
      sign_q <= bus.portA[WIDTH-1] ^ bus.portB[WIDTH-1];
    end
  end
`else
  assign mag_a_c  = bus.portA;
  assign mag_b_c  = bus.portB;
  assign result_c = pp_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= START;
    else      state <= next_state;
  end

  // Next-state logic: test LSB of multiplier, add if set, then shift.
  always_comb begin
    next_state = state;
    case (state)
      START:   if (bus.init) next_state = CHECK;
      CHECK:   next_state = b_q[0] ? ADD : SHIFT;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = (ct_q == CW'(1)) ? END : CHECK;
      END:     next_state = START;
      default: next_state = START;
    endcase
  end

  // Datapath: operand load, accumulate, shift, commit result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      pp_q <= '0;
      ct_q <= '0;
      bus.P <= '0;
    end else begin
      case (state)
        START: begin
          if (bus.init) begin
            a_q  <= {{WIDTH{1'b0}}, mag_a_c};
            b_q  <= mag_b_c;
            pp_q <= '0;
            ct_q <= CW'(WIDTH);
          end
        end
        ADD: pp_q <= pp_q + a_q;
        SHIFT: begin
          a_q  <= a_q << 1;
          b_q  <= b_q >> 1;
          ct_q <= ct_q - CW'(1);
          if (ct_q == CW'(1)) bus.P <= result_c;
        end
        default: ;
      endcase
    end
  end

  // Completion strobe, registered so it is high exactly while in END.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.done <= 1'b0;
    else      bus.done <= (next_state == END);
  end

endmodule
